// File: rtl/angle_frame_pkg.sv
// Shared constants, FSM encoding, frame payload type and CRC-8 helper for angle_frame_tx.
package angle_frame_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN      = 8;
  localparam logic [7:0]  CRC8_POLY      = 8'h07;
  localparam logic [7:0]  CRC8_INIT      = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [4:0]  mode;
    logic [7:0]  seq;
    logic [31:0] angle;
    logic [7:0]  chk;
  } frame_t;

  // CRC-8, MSB first, no reflection: fold one byte into the running value.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter; done marks the last cycle of the stop bit so the
// next byte can be chained without an idle gap.
module uart_byte_tx
  import angle_frame_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd40
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       txd,
  output logic       done
);

  tx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        txd_d, done_d;
  logic        bit_end;

  assign bit_end = (timer_q == BAUD_DIV - 16'd1);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd       <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      txd       <= txd_d;
      done      <= done_d;
    end
  end

  // Next-state and registered-output values; STOP may chain straight into START.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    txd_d     = txd;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        txd_d   = 1'b1;
        if (start) begin
          state_d = ST_START;
          txd_d   = 1'b0;
          shreg_d = byte_in;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          timer_d   = '0;
          bit_idx_d = '0;
          txd_d     = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        done_d = (timer_q == BAUD_DIV - 16'd2);
        if (bit_end) begin
          timer_d = '0;
          if (start) begin
            state_d = ST_START;
            txd_d   = 1'b0;
            shreg_d = byte_in;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/angle_frame_tx.sv
// Frames angle samples into 8-byte UART packets. Define ANGLE_FRAME_CRC8_EN to
// replace the mod-256 sum check byte with CRC-8/0x07.
module angle_frame_tx
  import angle_frame_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd40,
  parameter logic [7:0]  HEADER   = HEADER_DEFAULT
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        sample_vld,
  input  logic [31:0] angle_in,
  input  logic [4:0]  mode,
  output logic        txd,
  output logic        busy,
  output logic [7:0]  seq,
  output logic [15:0] drop_cnt
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

  frame_t     frame_q;
  logic [2:0] byte_idx_q;
  logic [2:0] next_idx;
  logic [7:0] chk_calc;
  logic [7:0] tx_byte;
  logic       byte_done;
  logic       byte_start;
  logic       accept;
  logic       next_byte;
  logic       frame_end;

  assign accept     = sample_vld & ~busy;
  assign next_byte  = byte_done && (byte_idx_q != LAST_BYTE);
  assign frame_end  = byte_done && (byte_idx_q == LAST_BYTE);
  assign byte_start = accept | next_byte;
  assign next_idx   = byte_idx_q + 3'd1;

  // Check byte over bytes 1..6, computed from the live inputs on the accepting edge.
  always_comb begin
`ifdef ANGLE_FRAME_CRC8_EN
    chk_calc = CRC8_INIT;
    chk_calc = crc8_byte(chk_calc, {3'b000, mode});
    chk_calc = crc8_byte(chk_calc, seq);
    chk_calc = crc8_byte(chk_calc, angle_in[31:24]);
    chk_calc = crc8_byte(chk_calc, angle_in[23:16]);
    chk_calc = crc8_byte(chk_calc, angle_in[15:8]);
    chk_calc = crc8_byte(chk_calc, angle_in[7:0]);
`else
    chk_calc = {3'b000, mode} + seq + angle_in[31:24] + angle_in[23:16]
             + angle_in[15:8] + angle_in[7:0];
`endif
  end

  always_comb begin
    tx_byte = HEADER;
    if (!accept) begin
      case (next_idx)
        3'd1:    tx_byte = {3'b000, frame_q.mode};
        3'd2:    tx_byte = frame_q.seq;
        3'd3:    tx_byte = frame_q.angle[31:24];
        3'd4:    tx_byte = frame_q.angle[23:16];
        3'd5:    tx_byte = frame_q.angle[15:8];
        3'd6:    tx_byte = frame_q.angle[7:0];
        3'd7:    tx_byte = frame_q.chk;
        default: tx_byte = HEADER;
      endcase
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      byte_idx_q <= '0;
      busy       <= 1'b0;
      seq        <= '0;
    end else if (accept) begin
      frame_q.mode  <= mode;
      frame_q.seq   <= seq;
      frame_q.angle <= angle_in;
      frame_q.chk   <= chk_calc;
      byte_idx_q    <= '0;
      busy          <= 1'b1;
      seq           <= seq + 8'd1;
    end else if (next_byte) begin
      byte_idx_q <= next_idx;
    end else if (frame_end) begin
      busy <= 1'b0;
    end
  end

  // Saturating count of samples that arrived while a frame was in flight.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (sample_vld && busy && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .start    (byte_start),
    .byte_in  (tx_byte),
    .txd      (txd),
    .done     (byte_done)
  );

endmodule

// File: doc/angle_frame_tx.md
# angle_frame_tx

Serialises each angle sample produced by the encoder front end into a fixed 8-byte UART frame for the host/monitor link. It sits directly downstream of the encoder mode-select stage and consumes its 32-bit angle word, 5-bit mode, and the periodic acquisition strobe. Samples are accepted only while the link is idle; a sample that arrives during transmission is dropped and counted.

## Interface
- `BAUD_DIV`, default 16'd40: clk_100M cycles per UART bit, giving 2.5 Mbaud. Legal range is ≥ 2.
- `HEADER`, default 8'hA5: the first byte of every frame.
- `clk_100M`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `sample_vld`, input, 1 bit: one-cycle strobe meaning the angle is ready (the acquisition request, 1 per CNT_FREQ+1 cycles).
- `angle_in`, input, 32 bits: encoder angle word.
- `mode`, input, 5 bits: active encoder mode, one-hot or 0.
- `txd`, output, 1 bit: UART serial out. Idles high.
- `busy`, output, 1 bit: high while a frame is in flight.
- `seq`, output, 8 bits: sequence number of the next frame.
- `drop_cnt`, output, 16 bits: count of rejected samples. Saturates.

## Operation
- Frame is 8 bytes, sent in this order: HEADER, {3'b000,mode}, seq, angle[31:24], angle[23:16], angle[15:8], angle[7:0], CHK.
- Each byte is framed as start bit 0, then 8 data bits LSB first, then 1 stop bit. There is no parity and no idle gap between bytes.
- CHK is the mod-256 sum of bytes 1..6 (HEADER excluded); see Configuration for the CRC alternative.
- Accept rule: at a clk edge with sample_vld=1 and busy=0, the block latches angle_in, mode and seq into the frame buffer. Later input changes do not affect the frame in flight.
- Reject rule: sample_vld=1 with busy=1 is dropped, and drop_cnt increments, holding at 16'hFFFF.
- seq increments by 1 on each accepted sample, wrapping 8'hFF→8'h00. The frame carries the pre-increment value.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after BAUD_DIV cycles.
  - DATA → STOP after 8 bits.
  - STOP → START (next byte) or IDLE (after CHK).
- Counters:
  - bit-timer 16-bit, counting 0..BAUD_DIV-1.
  - bit index 3-bit.
  - byte index 3-bit.
- Reset values: txd=1, busy=0, seq=0, drop_cnt=0, FSM=IDLE, frame buffer=0.
- Reset mid-frame: txd returns high asynchronously and the frame is abandoned. There is no resume.

## Timing
- txd and busy are registered outputs. On the accepting edge, busy goes to 1 and txd goes to 0 (start of the HEADER start bit). Latency is 0 cycles after that edge.
- Every bit is held exactly BAUD_DIV cycles. A byte takes 10·BAUD_DIV cycles; a frame takes 80·BAUD_DIV cycles (3200 at the default).
- busy falls on the edge that ends the CHK stop bit, with txd=1. sample_vld on that same edge is still rejected (busy=1 sampled). It is accepted from the next edge onward.
- With default CNT_FREQ 5000, the sample period is 5001 cycles, which exceeds 3200, so no drops occur in normal operation.
- All logic is in the clk_100M domain. Inputs are already synchronous, so no CDC is needed.

## Configuration
- `ANGLE_FRAME_CRC8_EN` defined: CHK is CRC-8 over bytes 1..6.
  - Polynomial 0x07, init 8'h00, no reflection, no final XOR, processed MSB first.
  - It is computed bytewise when the frame is latched, finishing before the CHK byte starts.
- Undefined: CHK is the mod-256 sum. Frame length and timing are identical in both cases.

## Structure
- Shared package `angle_frame_pkg` holds:
  - HEADER default and frame length (8).
  - FSM state encoding.
  - CRC-8 polynomial and init constants.
  - a CRC-8 byte-update function.
- One sub-module: `uart_byte_tx`. It has ports clk_100M, rst_n, start, byte_in[7:0], BAUD_DIV param, and outputs txd, done (1-cycle).
- The top holds the frame buffer, byte sequencing, seq, drop_cnt and checksum.

## Test plan
- Test 1, basic frame: after reset, apply sample_vld with angle_in=32'h12345678, mode=5'b00010.
  - Decoded txd bytes must be A5 02 00 12 34 56 78 16 (sum build).
  - Each bit must be 40 cycles wide, and busy must be high for exactly 3200 cycles.
  - seq must read 1 afterwards.
- Test 2, CRC build: the same stimulus with ANGLE_FRAME_CRC8_EN defined. CHK must equal the CRC-8/0x07 model of 02 00 12 34 56 78; all other bytes are unchanged.
- Test 3, drop while busy: apply a second sample_vld 100 cycles after the first.
  - The second sample must produce no extra frame, and drop_cnt must be 1.
  - A sample on the busy-fall edge must also be dropped; a sample one cycle later must be accepted.
- Test 4, wrap and saturation:
  - Send 257 frames; the seq byte must go …FE FF 00, with seq=1 at the end.
  - Force 65537 drops; drop_cnt must hold at 16'hFFFF.
- Test 5, reset mid-frame:
  - Assert rst_n low during the byte-3 data bits. txd must go to 1 immediately; busy, seq and drop_cnt must clear.
  - After release, a new sample must give a clean frame with seq 00.
- Test 6, periodic stream: drive sample_vld every 5001 cycles for 20 samples with changing angle/mode.
  - All 20 frames must decode correctly with consecutive seq, and drop_cnt must be 0.
